// File: rtl/ej32_mem_arb.sv
// rtl/ej32_mem_arb.sv - three-way byte memory port arbiter with LS lock and DMA starvation bound
//
// Shares one byte-wide memory port between instruction fetch (if_*), the
// load/store unit (ls_*) and the console DMA (dma_*).
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt           fetch read requester
//   ls_req/ls_lock/ls_we/ls_addr/
//   ls_wdata/ls_gnt                 load/store requester, ls_lock holds the bus for a burst
//   dma_req/dma_we/dma_addr/
//   dma_wdata/dma_gnt               console DMA requester
//   mem_addr/mem_we/mem_wdata       memory command, driven by the current winner
//   mem_rdata                       memory read byte, one cycle after the address
//   rdata_o/rvalid_o                read byte and one-hot {dma,ls,if} owner tag
module ej32_mem_arb #(
    parameter int ASZ    = 17,
    parameter int STARVE = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [ASZ-1:0] if_addr,
    output logic           if_gnt,
    input  logic           ls_req,
    input  logic           ls_lock,
    input  logic           ls_we,
    input  logic [ASZ-1:0] ls_addr,
    input  logic [7:0]     ls_wdata,
    output logic           ls_gnt,
    input  logic           dma_req,
    input  logic           dma_we,
    input  logic [ASZ-1:0] dma_addr,
    input  logic [7:0]     dma_wdata,
    output logic           dma_gnt,
    output logic [ASZ-1:0] mem_addr,
    output logic           mem_we,
    output logic [7:0]     mem_wdata,
    input  logic [7:0]     mem_rdata,
    output logic [7:0]     rdata_o,
    output logic [2:0]     rvalid_o
);

    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    logic          lock_q, lock_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [2:0]    owner_q, owner_d;
    logic          promoted;

    assign promoted = (starve_q == STARVE_MAX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= 1'b0;
            starve_q <= '0;
            owner_q  <= 3'b000;
        end else begin
            lock_q   <= lock_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        lock_d = lock_q;
        if (ls_gnt)
            lock_d = ls_lock;
        else if (!ls_req)
            lock_d = 1'b0;

        starve_d = starve_q;
        if (dma_gnt || !dma_req)
            starve_d = '0;
        else if (starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);

        // Only granted reads produce a return tag for the next cycle.
        owner_d = 3'b000;
        if (if_gnt)
            owner_d = 3'b001;
        if (ls_gnt && !ls_we)
            owner_d = 3'b010;
        if (dma_gnt && !dma_we)
            owner_d = 3'b100;
    end

    // Outputs: grant decision and memory mux
    always_comb begin
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        dma_gnt = 1'b0;
        if (rst) begin
            // no grants while reset is held
        end else if (lock_q && ls_req) begin
            // an open LS burst beats even a promoted DMA
            ls_gnt = 1'b1;
        end else if (promoted && dma_req) begin
            dma_gnt = 1'b1;
        end else if (ls_req) begin
            ls_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
        end

        mem_addr  = if_addr;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_we    = ls_we;
            mem_wdata = ls_wdata;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_we    = dma_we;
            mem_wdata = dma_wdata;
        end

        rdata_o  = mem_rdata;
        rvalid_o = owner_q;
    end

endmodule

// File: tb/tb_ej32_mem_arb.sv
// tb/tb_ej32_mem_arb.sv - table-driven and sequence checks for ej32_mem_arb
module tb_ej32_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [16:0] if_addr;
    logic        if_gnt;
    logic        ls_req, ls_lock, ls_we;
    logic [16:0] ls_addr;
    logic [7:0]  ls_wdata;
    logic        ls_gnt;
    logic        dma_req, dma_we;
    logic [16:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  rdata_o;
    logic [2:0]  rvalid_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ej32_mem_arb #(.ASZ(17), .STARVE(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .ls_req(ls_req), .ls_lock(ls_lock), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata_o(rdata_o), .rvalid_o(rvalid_o)
    );

    typedef struct {
        logic        if_req;
        logic [16:0] if_addr;
        logic        ls_req;
        logic        ls_lock;
        logic        ls_we;
        logic [16:0] ls_addr;
        logic [7:0]  ls_wdata;
        logic        dma_req;
        logic        dma_we;
        logic [16:0] dma_addr;
        logic [7:0]  dma_wdata;
        logic [2:0]  gnt;      // {dma,ls,if}
        logic [16:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [2:0]  rv;       // rvalid_o after the clock edge
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [16:0] ia,
        input logic lr, input logic ll, input logic lw, input logic [16:0] la, input logic [7:0] ld,
        input logic dr, input logic dw, input logic [16:0] da, input logic [7:0] dd,
        input logic [2:0] g, input logic [16:0] ea, input logic ew, input logic [7:0] ed,
        input logic [2:0] rv);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;
        v.ls_req = lr;  v.ls_lock = ll; v.ls_we = lw; v.ls_addr = la; v.ls_wdata = ld;
        v.dma_req = dr; v.dma_we = dw;  v.dma_addr = da; v.dma_wdata = dd;
        v.gnt = g; v.addr = ea; v.we = ew; v.wdata = ed; v.rv = rv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_req = v.if_req;  if_addr = v.if_addr;
        ls_req = v.ls_req;  ls_lock = v.ls_lock; ls_we = v.ls_we;
        ls_addr = v.ls_addr; ls_wdata = v.ls_wdata;
        dma_req = v.dma_req; dma_we = v.dma_we;
        dma_addr = v.dma_addr; dma_wdata = v.dma_wdata;
        mem_rdata = 8'($urandom);
    endtask

    // One cycle: drive at negedge, check comb outputs, then check read return after posedge.
    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({name, ".gnt"}, {29'd0, dma_gnt, ls_gnt, if_gnt}, {29'd0, v.gnt});
        chk({name, ".addr"}, {15'd0, mem_addr}, {15'd0, v.addr});
        chk({name, ".we"}, {31'd0, mem_we}, {31'd0, v.we});
        chk({name, ".wdata"}, {24'd0, mem_wdata}, {24'd0, v.wdata});
        @(posedge clk);
        #1;
        chk({name, ".rvalid"}, {29'd0, rvalid_o}, {29'd0, v.rv});
        chk({name, ".rdata"}, {24'd0, rdata_o}, {24'd0, mem_rdata});
    endtask

    vec_t tbl[8];
    vec_t idle;

    initial begin
        idle = mk(0, 17'h0, 0, 0, 0, 17'h0, 8'h0, 0, 0, 17'h0, 8'h0, 3'b000, 17'h0, 0, 8'h0, 3'b000);

        //           if        ls                                dma                            expected
        tbl[0] = mk(1, 17'h00100, 0, 0, 0, 17'h0,     8'h00, 0, 0, 17'h0,     8'h00, 3'b001, 17'h00100, 0, 8'h00, 3'b001);
        tbl[1] = mk(1, 17'h00100, 1, 0, 0, 17'h01000, 8'h00, 1, 0, 17'h01400, 8'h00, 3'b010, 17'h01000, 0, 8'h00, 3'b010);
        tbl[2] = mk(1, 17'h00200, 0, 0, 0, 17'h0,     8'h00, 1, 0, 17'h01400, 8'h00, 3'b001, 17'h00200, 0, 8'h00, 3'b001);
        tbl[3] = mk(0, 17'h00200, 0, 0, 0, 17'h0,     8'h00, 1, 1, 17'h01400, 8'h41, 3'b100, 17'h01400, 1, 8'h41, 3'b000);
        tbl[4] = mk(1, 17'h00200, 1, 0, 1, 17'h03000, 8'h7F, 0, 0, 17'h0,     8'h00, 3'b010, 17'h03000, 1, 8'h7F, 3'b000);
        tbl[5] = mk(0, 17'h00ABC, 0, 0, 1, 17'h03000, 8'h55, 0, 1, 17'h01400, 8'h66, 3'b000, 17'h00ABC, 0, 8'h00, 3'b000);
        tbl[6] = mk(1, 17'h00300, 0, 1, 0, 17'h03000, 8'h00, 0, 0, 17'h0,     8'h00, 3'b001, 17'h00300, 0, 8'h00, 3'b001);
        tbl[7] = mk(0, 17'h00300, 0, 0, 0, 17'h0,     8'h00, 1, 0, 17'h01500, 8'h00, 3'b100, 17'h01500, 0, 8'h00, 3'b100);

        // Reset state: requests present but nothing granted, no rvalid.
        rst = 1'b1;
        drive(tbl[1]);
        #2;
        chk("reset.gnt", {29'd0, dma_gnt, ls_gnt, if_gnt}, 32'd0);
        chk("reset.we", {31'd0, mem_we}, 32'd0);
        chk("reset.rvalid", {29'd0, rvalid_o}, 32'd0);
        @(negedge clk);
        drive(idle);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Locked LS burst with IF waiting; IF gets the bus once LS releases.
        step("burst0", mk(1, 17'h00100, 1, 1, 0, 17'h02000, 8'h00, 0, 0, 17'h0, 8'h00, 3'b010, 17'h02000, 0, 8'h00, 3'b010));
        step("burst1", mk(1, 17'h00100, 1, 1, 0, 17'h02001, 8'h00, 0, 0, 17'h0, 8'h00, 3'b010, 17'h02001, 0, 8'h00, 3'b010));
        step("burst2", mk(1, 17'h00100, 1, 1, 0, 17'h02002, 8'h00, 0, 0, 17'h0, 8'h00, 3'b010, 17'h02002, 0, 8'h00, 3'b010));
        step("burst3", mk(1, 17'h00100, 1, 0, 0, 17'h02003, 8'h00, 0, 0, 17'h0, 8'h00, 3'b010, 17'h02003, 0, 8'h00, 3'b010));
        step("burst4", mk(1, 17'h00100, 0, 0, 0, 17'h02004, 8'h00, 0, 0, 17'h0, 8'h00, 3'b001, 17'h00100, 0, 8'h00, 3'b001));
        step("idle0", idle);

        // DMA starvation: granted on the 9th waiting cycle, then counter restarts.
        for (int i = 1; i <= 9; i++) begin
            if (i < 9)
                step($sformatf("starve%0d", i), mk(1, 17'h00100, 1, 0, 0, 17'h04000, 8'h00, 1, 0, 17'h05000, 8'h00, 3'b010, 17'h04000, 0, 8'h00, 3'b010));
            else
                step("starve9", mk(1, 17'h00100, 1, 0, 0, 17'h04000, 8'h00, 1, 0, 17'h05000, 8'h00, 3'b100, 17'h05000, 0, 8'h00, 3'b100));
        end
        step("starve_after", mk(1, 17'h00100, 1, 0, 0, 17'h04000, 8'h00, 1, 0, 17'h05000, 8'h00, 3'b010, 17'h04000, 0, 8'h00, 3'b010));
        step("idle1", idle);

        // A lock holds off even a promoted DMA; DMA wins right after the lock drops.
        for (int i = 0; i < 10; i++)
            step($sformatf("lockstarve%0d", i), mk(0, 17'h0, 1, 1, 0, 17'h06000, 8'h00, 1, 0, 17'h05000, 8'h00, 3'b010, 17'h06000, 0, 8'h00, 3'b010));
        step("lockstarve_end", mk(0, 17'h0, 1, 0, 0, 17'h06000, 8'h00, 1, 0, 17'h05000, 8'h00, 3'b010, 17'h06000, 0, 8'h00, 3'b010));
        step("promoted_win", mk(0, 17'h0, 1, 0, 0, 17'h06000, 8'h00, 1, 0, 17'h05000, 8'h00, 3'b100, 17'h05000, 0, 8'h00, 3'b100));
        step("idle2", idle);

        // Reset in the middle of a burst, with a read return pending.
        step("rburst0", mk(1, 17'h00100, 1, 1, 0, 17'h02000, 8'h00, 0, 0, 17'h0, 8'h00, 3'b010, 17'h02000, 0, 8'h00, 3'b010));
        step("rburst1", mk(1, 17'h00100, 1, 1, 1, 17'h02001, 8'h11, 0, 0, 17'h0, 8'h00, 3'b010, 17'h02001, 1, 8'h11, 3'b000));
        step("rburst2", mk(1, 17'h00100, 1, 1, 0, 17'h02002, 8'h00, 0, 0, 17'h0, 8'h00, 3'b010, 17'h02002, 0, 8'h00, 3'b010));
        @(negedge clk);
        drive(mk(1, 17'h00100, 1, 1, 1, 17'h02003, 8'h22, 1, 1, 17'h01400, 8'h33, 3'b000, 17'h0, 0, 8'h00, 3'b000));
        #1;
        chk("midrst.rvalid_pre", {29'd0, rvalid_o}, 32'd2);
        rst = 1'b1;
        #1;
        chk("midrst.gnt", {29'd0, dma_gnt, ls_gnt, if_gnt}, 32'd0);
        chk("midrst.we", {31'd0, mem_we}, 32'd0);
        chk("midrst.rvalid", {29'd0, rvalid_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_if", mk(1, 17'h00100, 0, 0, 0, 17'h0, 8'h00, 0, 0, 17'h0, 8'h00, 3'b001, 17'h00100, 0, 8'h00, 3'b001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
